// File: rtl/core_defs.sv
// Shared definitions for the load/store path: funct3 and store encodings,
// LSU state encoding, access-size decode and alignment helpers.
package core_defs;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SC_SB = 2'b00;
  localparam logic [1:0] SC_SH = 2'b01;
  localparam logic [1:0] SC_SW = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_e;

  // Reserved load encodings fall through to a full-word access.
  function automatic acc_size_e load_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_BYTE;
      F3_LH, F3_LHU: return SZ_HALF;
      F3_LW:         return SZ_WORD;
      default:       return SZ_WORD;
    endcase
  endfunction

  function automatic acc_size_e store_size(input logic [1:0] sc);
    case (sc)
      SC_SB:   return SZ_BYTE;
      SC_SH:   return SZ_HALF;
      SC_SW:   return SZ_WORD;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [1:0] align_offset(input acc_size_e sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return a;
      SZ_HALF: return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      default: return |a;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the byte or halfword lane from the read word
// and sign- or zero-extends it to the register width.
module lsu_load_align
  import core_defs::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        off,
  input  logic [2:0]        load_ctrl,
  output logic [DATA_W-1:0] result
);

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] v, input logic sgn);
    return {{(DATA_W-8){sgn & v[7]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] v, input logic sgn);
    return {{(DATA_W-16){sgn & v[15]}}, v};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sgn;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    sgn      = !(load_ctrl == F3_LBU || load_ctrl == F3_LHU);
    result   = rdata;
    case (load_size(load_ctrl))
      SZ_BYTE: result = ext_byte(byte_sel, sgn);
      SZ_HALF: result = ext_half(half_sel, sgn);
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: valid/ready data bus master with byte lanes,
// load extension, pipeline stall and bus timeout. Option: LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import core_defs::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  lsuValid,
  input  logic                  memWrite,
  input  logic [2:0]            loadCtrl,
  input  logic [1:0]            storeCtrl,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_W-1:0]     storeData,
  output logic                  stall,
  output logic [DATA_W-1:0]     loadResult,
  output logic                  loadValid,
  output logic                  busError,
  output logic                  memReq,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [3:0]            memBe,
  output logic [DATA_W-1:0]     memWData,
  input  logic                  memReady,
  input  logic                  memRespValid,
  input  logic [DATA_W-1:0]     memRData
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e              state_q;
  logic                    we_p0;
  logic [2:0]              lctrl_p0;
  logic [1:0]              off_p0;
  logic [ADDR_WIDTH-3:0]   word_addr_p0;
  logic [3:0]              be_p0;
  logic [DATA_W-1:0]       wdata_p0;
  logic [DATA_W-1:0]       rdata_p0;
  logic [CNT_W-1:0]        cnt_q;
  logic                    err_q;

  acc_size_e               req_size;
  logic [1:0]              req_off;
  logic [3:0]              req_be;
  logic [DATA_W-1:0]       req_wdata;
  logic                    misalign;
  logic                    timeout_hit;
  logic [DATA_W-1:0]       align_result;

  // Issue-cycle decode: lane offset (masked to the access size), enables, replicated data.
  always_comb begin
    req_size  = memWrite ? store_size(storeCtrl) : load_size(loadCtrl);
    req_off   = align_offset(req_size, addr[1:0]);
    req_be    = 4'b1111;
    req_wdata = storeData;
    case (req_size)
      SZ_BYTE: begin
        req_be    = 4'b0001 << req_off;
        req_wdata = {4{storeData[7:0]}};
      end
      SZ_HALF: begin
        req_be    = 4'b0011 << req_off;
        req_wdata = {2{storeData[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = storeData;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(req_size, addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      we_p0        <= 1'b0;
      lctrl_p0     <= '0;
      off_p0       <= '0;
      word_addr_p0 <= '0;
      be_p0        <= '0;
      wdata_p0     <= '0;
      rdata_p0     <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (lsuValid) begin
            if (misalign) begin
              err_q <= 1'b1;
            end else begin
              we_p0        <= memWrite;
              lctrl_p0     <= loadCtrl;
              off_p0       <= req_off;
              word_addr_p0 <= addr[ADDR_WIDTH-1:2];
              be_p0        <= req_be;
              wdata_p0     <= req_wdata;
              state_q      <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (memReady) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end else if (timeout_hit) begin
            cnt_q   <= '0;
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        // A response in the same cycle as the request handshake is not taken here.
        S_WAIT: begin
          if (memRespValid) begin
            cnt_q    <= '0;
            rdata_p0 <= memRData;
            state_q  <= S_DONE;
          end else if (timeout_hit) begin
            cnt_q   <= '0;
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  lsu_load_align u_align (
    .rdata     (rdata_p0),
    .off       (off_p0),
    .load_ctrl (lctrl_p0),
    .result    (align_result)
  );

  assign memReq     = (state_q == S_REQ);
  assign memWe      = memReq & we_p0;
  assign memAddr    = memReq ? {word_addr_p0, 2'b00} : '0;
  assign memBe      = memReq ? be_p0 : '0;
  assign memWData   = memReq ? wdata_p0 : '0;
  assign stall      = ((state_q == S_IDLE) && lsuValid) || (state_q == S_REQ) || (state_q == S_WAIT);
  assign loadValid  = (state_q == S_DONE) && !we_p0;
  assign loadResult = loadValid ? align_result : '0;
  assign busError   = err_q;

endmodule
